// File: rtl/idli_pkg.sv
// Shared idli types: nibble bus and register file sizing.
// Register file forwarding is selected with IDLI_RF_WB_FWD_EN.
package idli_pkg;

   typedef logic [3:0] sqi_data_t;

   localparam int RF_NUM_REGS = 16;

   typedef logic [3:0]  rf_idx_t;
   typedef logic [15:0] rf_data_t;

   typedef enum logic [0:0] {
      RF_IDLE,
      RF_STREAM
   } rf_state_t;

endpackage

// File: rtl/idli_rf_shift_m.sv
// 16b load / shift-right-by-4 register presenting its low nibble.
// Shifting in zeros leaves the register cleared after four shifts.
module idli_rf_shift_m
   import idli_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  logic      shift,
   input  rf_data_t  din,
   output sqi_data_t nib
);

   rf_data_t data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= din;
      end else if (shift) begin
         data_q <= {4'h0, data_q[15:4]};
      end
   end

   assign nib = data_q[3:0];

endmodule

// File: rtl/idli_rf_m.sv
// Nibble-serial register file: 16x16b, serial read stream, nibble writeback.
// Define IDLI_RF_WB_FWD_EN to forward a same-edge commit into a read snapshot.
module idli_rf_m
   import idli_pkg::*;
(
   input  logic      i_rf_gck,
   input  logic      i_rf_rst,
   input  logic      i_rf_start,
   input  rf_idx_t   i_rf_lhs_idx,
   input  rf_idx_t   i_rf_rhs_idx,
   output logic      o_rf_busy,
   output logic [1:0] o_rf_ctr,
   output sqi_data_t o_rf_lhs,
   output sqi_data_t o_rf_rhs,
   input  logic      i_rf_wr_vld,
   input  rf_idx_t   i_rf_wr_idx,
   input  sqi_data_t i_rf_wr_data,
   output logic      o_rf_wr_done
);

   rf_data_t   regs_q [RF_NUM_REGS];

   logic [1:0]  wr_ctr_q;
   logic [11:0] wr_acc_q;
   rf_idx_t     wr_idx_q;
   logic        wr_done_q;
   logic        wr_last;
   rf_data_t    wr_val;

   rf_state_t   state_q;
   logic [1:0]  ctr_q;
   logic        streaming;
   logic        load;
   logic        shift;
   rf_data_t    lhs_val;
   rf_data_t    rhs_val;

   assign wr_last = i_rf_wr_vld && (wr_ctr_q == 2'd3);
   assign wr_val  = {i_rf_wr_data, wr_acc_q};

   // Nibbles enter at the top so nibble 0 ends up in [3:0] after three.
   always_ff @(posedge i_rf_gck or posedge i_rf_rst) begin
      if (i_rf_rst) begin
         wr_ctr_q  <= '0;
         wr_acc_q  <= '0;
         wr_idx_q  <= '0;
         wr_done_q <= 1'b0;
      end else begin
         wr_done_q <= wr_last;
         if (i_rf_wr_vld) begin
            wr_ctr_q <= wr_ctr_q + 2'd1;
            wr_acc_q <= {i_rf_wr_data, wr_acc_q[11:4]};
            if (wr_ctr_q == 2'd0) begin
               wr_idx_q <= i_rf_wr_idx;
            end
         end
      end
   end

   always_ff @(posedge i_rf_gck or posedge i_rf_rst) begin
      if (i_rf_rst) begin
         for (int i = 0; i < RF_NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_last && (wr_idx_q != '0)) begin
         regs_q[wr_idx_q] <= wr_val;
      end
   end

   always_comb begin
      lhs_val = regs_q[i_rf_lhs_idx];
      rhs_val = regs_q[i_rf_rhs_idx];
`ifdef IDLI_RF_WB_FWD_EN
      if (wr_last && (wr_idx_q == i_rf_lhs_idx)) begin
         lhs_val = wr_val;
      end
      if (wr_last && (wr_idx_q == i_rf_rhs_idx)) begin
         rhs_val = wr_val;
      end
`endif
      if (i_rf_lhs_idx == '0) begin
         lhs_val = '0;
      end
      if (i_rf_rhs_idx == '0) begin
         rhs_val = '0;
      end
   end

   assign streaming = (state_q == RF_STREAM);
   assign load      = i_rf_start && (!streaming || (ctr_q == 2'd3));
   assign shift     = streaming && !load;

   // ctr wraps 3 -> 0 on the way back to idle.
   always_ff @(posedge i_rf_gck or posedge i_rf_rst) begin
      if (i_rf_rst) begin
         state_q <= RF_IDLE;
         ctr_q   <= '0;
      end else if (load) begin
         state_q <= RF_STREAM;
         ctr_q   <= '0;
      end else if (streaming) begin
         ctr_q <= ctr_q + 2'd1;
         if (ctr_q == 2'd3) begin
            state_q <= RF_IDLE;
         end
      end
   end

   idli_rf_shift_m u_lhs (
      .clk   (i_rf_gck),
      .rst   (i_rf_rst),
      .load  (load),
      .shift (shift),
      .din   (lhs_val),
      .nib   (o_rf_lhs)
   );

   idli_rf_shift_m u_rhs (
      .clk   (i_rf_gck),
      .rst   (i_rf_rst),
      .load  (load),
      .shift (shift),
      .din   (rhs_val),
      .nib   (o_rf_rhs)
   );

   assign o_rf_busy    = streaming;
   assign o_rf_ctr     = ctr_q;
   assign o_rf_wr_done = wr_done_q;

endmodule

// File: tb/tb_idli_rf_m.sv
// Directed plus random bench for idli_rf_m against an array-based model.
// Honours IDLI_RF_WB_FWD_EN when predicting same-edge snapshots.
module tb_idli_rf_m;
   import idli_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   rf_idx_t    lhs_idx = '0;
   rf_idx_t    rhs_idx = '0;
   logic       busy;
   logic [1:0] ctr;
   sqi_data_t  lhs;
   sqi_data_t  rhs;
   logic       wr_vld = 1'b0;
   rf_idx_t    wr_idx = '0;
   sqi_data_t  wr_data = '0;
   logic       wr_done;

   int checks = 0;
   int failures = 0;
   logic [15:0] mdl [16];

   always #5 clk = ~clk;

   idli_rf_m dut (
      .i_rf_gck     (clk),
      .i_rf_rst     (rst),
      .i_rf_start   (start),
      .i_rf_lhs_idx (lhs_idx),
      .i_rf_rhs_idx (rhs_idx),
      .o_rf_busy    (busy),
      .o_rf_ctr     (ctr),
      .o_rf_lhs     (lhs),
      .o_rf_rhs     (rhs),
      .i_rf_wr_vld  (wr_vld),
      .i_rf_wr_idx  (wr_idx),
      .i_rf_wr_data (wr_data),
      .o_rf_wr_done (wr_done)
   );

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(start && busy && ctr != 2'd3)) else begin
            failures++;
            $error("FAIL protocol start while busy ctr=%0d", ctr);
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] nib(input logic [15:0] v, input int k);
      return (v >> (4 * k)) & 16'h000F;
   endfunction

   function automatic logic [15:0] mread(input rf_idx_t i);
      return (i == 0) ? 16'h0000 : mdl[i];
   endfunction

   task automatic wr(input rf_idx_t idx, input logic [15:0] v,
                     input int g1, input int g2, input int g3);
      int g[4];
      g = '{0, g1, g2, g3};
      for (int k = 0; k < 4; k++) begin
         repeat (g[k]) begin
            @(negedge clk);
            chk("wr_done_gap", 16'(wr_done), 16'h0);
         end
         wr_vld  = 1'b1;
         wr_idx  = (k == 0) ? idx : rf_idx_t'($urandom);
         wr_data = sqi_data_t'(nib(v, k));
         @(negedge clk);
         wr_vld = 1'b0;
         chk("wr_done", 16'(wr_done), (k == 3) ? 16'h1 : 16'h0);
         if (k == 3 && idx != 0) mdl[idx] = v;
      end
      @(negedge clk);
      chk("wr_done_pulse", 16'(wr_done), 16'h0);
   endtask

   task automatic start_rd(input rf_idx_t l, input rf_idx_t r);
      start   = 1'b1;
      lhs_idx = l;
      rhs_idx = r;
   endtask

   task automatic stream(input logic [15:0] el, input logic [15:0] er,
                         input bit done0, input bit chain,
                         input rf_idx_t nl, input rf_idx_t nr);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start  = 1'b0;
         wr_vld = 1'b0;
         chk("busy", 16'(busy), 16'h1);
         chk("ctr", 16'(ctr), 16'(k));
         chk("lhs", 16'(lhs), nib(el, k));
         chk("rhs", 16'(rhs), nib(er, k));
         chk("wr_done_rd", 16'(wr_done), (k == 0 && done0) ? 16'h1 : 16'h0);
         if (k == 3 && chain) start_rd(nl, nr);
      end
   endtask

   task automatic stream_end();
      @(negedge clk);
      chk("idle_busy", 16'(busy), 16'h0);
      chk("idle_ctr", 16'(ctr), 16'h0);
      chk("idle_out", {8'h0, lhs, rhs}, 16'h0);
   endtask

   task automatic rd(input rf_idx_t l, input rf_idx_t r);
      start_rd(l, r);
      stream(mread(l), mread(r), 1'b0, 1'b0, '0, '0);
      stream_end();
   endtask

   initial begin
      logic [15:0] exp5;
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0;

      #1;
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_ctr", 16'(ctr), 16'h0);
      chk("rst_out", {8'h0, lhs, rhs}, 16'h0);
      chk("rst_done", 16'(wr_done), 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      wr(4'd3, 16'hA5C3, 0, 0, 0);
      rd(4'd3, 4'd0);

      wr(4'd0, 16'hFFFF, 0, 0, 0);
      rd(4'd0, 4'd0);

      wr(4'd1, 16'h1234, 0, 0, 0);
      wr(4'd2, 16'hBEEF, 1, 0, 0);
      start_rd(4'd1, 4'd2);
      stream(16'h1234, 16'hBEEF, 1'b0, 1'b1, 4'd2, 4'd1);
      stream(16'hBEEF, 16'h1234, 1'b0, 1'b0, '0, '0);
      stream_end();

      wr(4'd5, 16'h1111, 0, 0, 0);
`ifdef IDLI_RF_WB_FWD_EN
      exp5 = 16'h2222;
`else
      exp5 = 16'h1111;
`endif
      wr_vld  = 1'b1;
      wr_idx  = 4'd5;
      wr_data = 4'h2;
      repeat (3) @(negedge clk);
      start_rd(4'd5, 4'd5);
      mdl[5] = 16'h2222;
      stream(exp5, exp5, 1'b1, 1'b0, '0, '0);
      stream_end();
      rd(4'd5, 4'd0);

      wr(4'd7, 16'h0F0F, 2, 0, 1);
      rd(4'd7, 4'd7);

      wr_vld  = 1'b1;
      wr_idx  = 4'd9;
      wr_data = 4'h6;
      repeat (2) @(negedge clk);
      wr_vld = 1'b0;
      start_rd(4'd3, 4'd7);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 16'(busy), 16'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 16'(busy), 16'h0);
      chk("arst_ctr", 16'(ctr), 16'h0);
      chk("arst_out", {8'h0, lhs, rhs}, 16'h0);
      chk("arst_done", 16'(wr_done), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
      @(negedge clk);
      chk("post_rst_done", 16'(wr_done), 16'h0);
      for (int i = 0; i < 16; i += 2) rd(rf_idx_t'(i), rf_idx_t'(i + 1));
      wr(4'd4, 16'h4321, 0, 0, 0);
      rd(4'd4, 4'd9);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            wr(rf_idx_t'($urandom), 16'($urandom),
               $urandom_range(2, 0), $urandom_range(2, 0),
               $urandom_range(2, 0));
         end else begin
            rf_idx_t l0, r0, l1, r1;
            bit ch;
            l0 = rf_idx_t'($urandom);
            r0 = rf_idx_t'($urandom);
            l1 = rf_idx_t'($urandom);
            r1 = rf_idx_t'($urandom);
            ch = 1'($urandom);
            start_rd(l0, r0);
            stream(mread(l0), mread(r0), 1'b0, ch, l1, r1);
            if (ch) stream(mread(l1), mread(r1), 1'b0, 1'b0, '0, '0);
            stream_end();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
